// File: rtl/l1_cpu_port.sv
// l1_cpu_port: one-at-a-time CPU load/store to 256-bit L1 line port (cpu_* core side, cache_* line side, stall until cache_valid)
module l1_cpu_port #(
  parameter int OFFSET_W = 5,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rden,
  input  logic              cpu_wren,
  input  logic [31:0]       cpu_addr,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_sign,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_err,
  output logic              cache_read,
  output logic              cache_write,
  output logic [31:0]       cache_addr,
  output logic [LINE_W-1:0] cache_wdata,
  output logic [LINE_W/8-1:0] cache_wmask,
  input  logic [LINE_W-1:0] cache_rdata,
  input  logic              cache_valid
);
  localparam int NB = LINE_W / 8;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] addr_q, wdata_q, load_word, load_val;
  logic [1:0] size_q;
  logic sign_q, wr_q, req, misalign, in_req;
  logic [7:0] lb;
  logic [15:0] lh;
  logic [NB-1:0] mask_base;
  logic [LINE_W-1:0] line_rep;
  always_comb begin
    req = cpu_rden | cpu_wren;
    misalign = (cpu_size == 2'b11) | ((cpu_size == 2'b01) & cpu_addr[0]) | ((cpu_size == 2'b10) & (|cpu_addr[1:0]));
    state_nx = (state == IDLE) ? (req ? (misalign ? DONE : REQ) : IDLE)
             : (state == REQ) ? (cache_valid ? DONE : REQ) : IDLE;
    in_req = state == REQ;
    load_word = cache_rdata[{addr_q[OFFSET_W-1:2], 5'b0} +: 32];
    lb = load_word[{addr_q[1:0], 3'b0} +: 8];
    lh = load_word[{addr_q[1], 4'b0} +: 16];
    load_val = (size_q == 2'b00) ? (sign_q ? {24'b0, lb} : {{24{lb[7]}}, lb})
             : (size_q == 2'b01) ? (sign_q ? {16'b0, lh} : {{16{lh[15]}}, lh}) : load_word;
    mask_base = (size_q == 2'b00) ? NB'(1) : (size_q == 2'b01) ? NB'(3) : NB'(15);
    line_rep = (size_q == 2'b00) ? {NB{wdata_q[7:0]}}
             : (size_q == 2'b01) ? {(NB/2){wdata_q[15:0]}} : {(NB/4){wdata_q}};
    cpu_stall = ~rst & (((state == IDLE) & req) | in_req);
    cache_read = in_req & ~wr_q;
    cache_write = in_req & wr_q;
    cache_addr = in_req ? {addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}} : '0;
    cache_wmask = cache_write ? mask_base << addr_q[OFFSET_W-1:0] : '0;
    cache_wdata = cache_write ? line_rep : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      size_q <= '0;
      sign_q <= 1'b0;
      wr_q <= 1'b0;
      cpu_rdata <= '0;
      cpu_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        addr_q <= cpu_addr;
        wdata_q <= cpu_wdata;
        size_q <= cpu_size;
        sign_q <= cpu_sign;
        wr_q <= cpu_wren;
        if (misalign) begin
          cpu_rdata <= '0;
          cpu_err <= 1'b1;
        end
      end
      if (in_req && cache_valid) begin
        cpu_rdata <= load_val;
        cpu_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_l1_cpu_port.sv
// tb_l1_cpu_port: directed self-checking bench for l1_cpu_port
module tb_l1_cpu_port;
  logic clk = 1'b0;
  logic rst, cpu_rden, cpu_wren, cpu_sign, cpu_stall, cpu_err;
  logic cache_read, cache_write, cache_valid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, cache_addr, cache_wmask;
  logic [1:0] cpu_size;
  logic [255:0] cache_wdata, cache_rdata, line;
  int pass_cnt = 0;
  int total = 0;

  l1_cpu_port dut (
    .clk(clk), .rst(rst), .cpu_rden(cpu_rden), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
    .cpu_size(cpu_size), .cpu_sign(cpu_sign), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .cpu_err(cpu_err), .cache_read(cache_read), .cache_write(cache_write),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_wmask(cache_wmask),
    .cache_rdata(cache_rdata), .cache_valid(cache_valid)
  );

  always #5 clk = ~clk;

  task automatic start(input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] sz,
                       input logic sg, input logic [31:0] wd);
    @(negedge clk);
    cpu_rden = rd; cpu_wren = wr; cpu_addr = a; cpu_size = sz; cpu_sign = sg; cpu_wdata = wd;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; cpu_rden = 1'b1; cpu_wren = 1'b0; cpu_addr = 32'h1008; cpu_size = 2'b10;
    cpu_sign = 1'b0; cpu_wdata = '0; cache_valid = 1'b0; cache_rdata = '0;
    repeat (2) begin
      @(negedge clk);
      total++; if (cache_read !== 1'b0) $display("FAIL rst_cache_read: got %b exp 0", cache_read); else pass_cnt++;
    end
    total++; if (cpu_stall !== 1'b0) $display("FAIL rst_stall: got %b exp 0", cpu_stall); else pass_cnt++;
    total++; if ({cpu_rdata, cpu_err, cache_write} !== 34'b0) $display("FAIL rst_cpu_out: got %h/%b/%b exp 0", cpu_rdata, cpu_err, cache_write); else pass_cnt++;
    total++; if ({cache_addr, cache_wmask} !== 64'b0 || cache_wdata !== 256'b0) $display("FAIL rst_cache_out: got %h/%h exp 0", cache_addr, cache_wmask); else pass_cnt++;
    cpu_rden = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_load;
    start(1'b1, 1'b0, 32'h0000_1008, 2'b10, 1'b0, 32'h0);
    total++; if ({cpu_stall, cache_read} !== 2'b10) $display("FAIL wl_c0: got stall/read %b exp 10", {cpu_stall, cache_read}); else pass_cnt++;
    @(negedge clk);
    total++; if ({cpu_stall, cache_read, cache_write} !== 3'b110) $display("FAIL wl_c1: got %b exp 110", {cpu_stall, cache_read, cache_write}); else pass_cnt++;
    total++; if (cache_addr !== 32'h0000_1000) $display("FAIL wl_addr: got %h exp 00001000", cache_addr); else pass_cnt++;
    line = '0; line[95:64] = 32'hDEAD_BEEF; line[63:32] = 32'h1111_2222;
    cache_rdata = line; cache_valid = 1'b1;
    @(negedge clk);
    cache_valid = 1'b0;
    total++; if ({cpu_stall, cache_read} !== 2'b00) $display("FAIL wl_done_ctl: got %b exp 00", {cpu_stall, cache_read}); else pass_cnt++;
    total++; if (cpu_rdata !== 32'hDEAD_BEEF) $display("FAIL wl_rdata: got %h exp deadbeef", cpu_rdata); else pass_cnt++;
    total++; if (cpu_err !== 1'b0) $display("FAIL wl_err: got %b exp 0", cpu_err); else pass_cnt++;
    cpu_rden = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_once(input logic [31:0] a, input logic [1:0] sz, input logic sg, input logic [255:0] l);
    start(1'b1, 1'b0, a, sz, sg, 32'h0);
    @(negedge clk);
    cache_rdata = l; cache_valid = 1'b1;
    @(negedge clk);
    cache_valid = 1'b0; cpu_rden = 1'b0;
  endtask

  task automatic test_byte_load;
    line = '0; line[31:0] = 32'h8033_2211; line[63:32] = 32'h7F7F_7F7F;
    load_once(32'h0000_2003, 2'b00, 1'b0, line);
    total++; if (cpu_rdata !== 32'hFFFF_FF80) $display("FAIL bl_sext: got %h exp ffffff80", cpu_rdata); else pass_cnt++;
    @(negedge clk);
    load_once(32'h0000_2003, 2'b00, 1'b1, line);
    total++; if (cpu_rdata !== 32'h0000_0080) $display("FAIL bl_zext: got %h exp 00000080", cpu_rdata); else pass_cnt++;
    @(negedge clk);
    load_once(32'h0000_2002, 2'b01, 1'b0, line);
    total++; if (cpu_rdata !== 32'hFFFF_8033) $display("FAIL hl_sext: got %h exp ffff8033", cpu_rdata); else pass_cnt++;
    @(negedge clk);
    load_once(32'h0000_2005, 2'b00, 1'b0, line);
    total++; if (cpu_rdata !== 32'h0000_007F) $display("FAIL bl_lane5: got %h exp 0000007f", cpu_rdata); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_half_store;
    start(1'b1, 1'b1, 32'h0000_3006, 2'b01, 1'b0, 32'hABCD_1234);
    @(negedge clk);
    total++; if ({cache_write, cache_read} !== 2'b10) $display("FAIL hs_ctl: got write/read %b exp 10", {cache_write, cache_read}); else pass_cnt++;
    total++; if (cache_wmask !== 32'h0000_00C0) $display("FAIL hs_mask: got %h exp 000000c0", cache_wmask); else pass_cnt++;
    total++; if (cache_wdata !== {16{16'h1234}}) $display("FAIL hs_wdata: got %h exp 1234x16", cache_wdata); else pass_cnt++;
    total++; if (cache_addr !== 32'h0000_3000) $display("FAIL hs_addr: got %h exp 00003000", cache_addr); else pass_cnt++;
    cache_valid = 1'b1;
    @(negedge clk);
    cache_valid = 1'b0;
    total++; if ({cpu_stall, cache_write, cpu_err} !== 3'b000) $display("FAIL hs_done: got %b exp 000", {cpu_stall, cache_write, cpu_err}); else pass_cnt++;
    cpu_rden = 1'b0; cpu_wren = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_masks;
    start(1'b0, 1'b1, 32'h0000_301F, 2'b00, 1'b0, 32'h0000_00A5);
    @(negedge clk);
    total++; if (cache_wmask !== 32'h8000_0000) $display("FAIL sb_mask: got %h exp 80000000", cache_wmask); else pass_cnt++;
    total++; if (cache_wdata !== {32{8'hA5}}) $display("FAIL sb_wdata: got %h exp a5x32", cache_wdata); else pass_cnt++;
    cache_valid = 1'b1;
    @(negedge clk);
    cache_valid = 1'b0; cpu_wren = 1'b0;
    start(1'b0, 1'b1, 32'h0000_301C, 2'b10, 1'b0, 32'h0123_4567);
    @(negedge clk);
    total++; if (cache_wmask !== 32'hF000_0000) $display("FAIL sw_mask: got %h exp f0000000", cache_wmask); else pass_cnt++;
    total++; if (cache_wdata !== {8{32'h0123_4567}}) $display("FAIL sw_wdata: got %h exp 01234567x8", cache_wdata); else pass_cnt++;
    cache_valid = 1'b1;
    @(negedge clk);
    cache_valid = 1'b0; cpu_wren = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wait_states;
    @(negedge clk);
    cache_valid = 1'b1; cache_rdata = '1;
    @(negedge clk);
    cache_valid = 1'b0;
    total++; if ({cpu_stall, cache_read, cache_write} !== 3'b000) $display("FAIL ws_idle_valid: got %b exp 000", {cpu_stall, cache_read, cache_write}); else pass_cnt++;
    start(1'b1, 1'b0, 32'h0000_500C, 2'b10, 1'b1, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      total++;
      if ({cpu_stall, cache_read} !== 2'b11 || cache_addr !== 32'h0000_5000)
        $display("FAIL ws_hold_c%0d: got stall/read %b addr %h exp 11 00005000", i, {cpu_stall, cache_read}, cache_addr);
      else pass_cnt++;
    end
    line = '0; line[127:96] = 32'hCAFE_F00D;
    cache_rdata = line; cache_valid = 1'b1;
    @(negedge clk);
    cache_valid = 1'b0;
    total++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'hCAFE_F00D) $display("FAIL ws_done: got stall %b rdata %h exp 0 cafef00d", cpu_stall, cpu_rdata); else pass_cnt++;
    cpu_rden = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_misaligned;
    start(1'b1, 1'b0, 32'h0000_4002, 2'b10, 1'b0, 32'h0);
    total++; if ({cpu_stall, cache_read} !== 2'b10) $display("FAIL ma_c0: got stall/read %b exp 10", {cpu_stall, cache_read}); else pass_cnt++;
    @(negedge clk);
    total++; if ({cpu_stall, cache_read, cache_write} !== 3'b000) $display("FAIL ma_c1_ctl: got %b exp 000", {cpu_stall, cache_read, cache_write}); else pass_cnt++;
    total++; if (cpu_err !== 1'b1 || cpu_rdata !== 32'h0) $display("FAIL ma_err: got err %b rdata %h exp 1 00000000", cpu_err, cpu_rdata); else pass_cnt++;
    cpu_rden = 1'b0;
    @(negedge clk);
    start(1'b1, 1'b0, 32'h0000_4000, 2'b11, 1'b0, 32'h0);
    @(negedge clk);
    total++; if (cpu_err !== 1'b1 || cache_read !== 1'b0) $display("FAIL ill_size: got err %b read %b exp 1 0", cpu_err, cache_read); else pass_cnt++;
    cpu_rden = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    line = '0; line[159:128] = 32'h5A5A_0001;
    start(1'b1, 1'b0, 32'h0000_6010, 2'b10, 1'b0, 32'h0);
    @(negedge clk);
    cache_rdata = line; cache_valid = 1'b1;
    @(negedge clk);
    cache_valid = 1'b0;
    total++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h5A5A_0001 || cpu_err !== 1'b0) $display("FAIL b2b_done: got stall %b rdata %h err %b exp 0 5a5a0001 0", cpu_stall, cpu_rdata, cpu_err); else pass_cnt++;
    @(negedge clk);
    total++; if ({cpu_stall, cache_read} !== 2'b10) $display("FAIL b2b_idle: got stall/read %b exp 10", {cpu_stall, cache_read}); else pass_cnt++;
    @(negedge clk);
    total++; if (cache_read !== 1'b1) $display("FAIL b2b_req: got %b exp 1", cache_read); else pass_cnt++;
    cache_valid = 1'b1;
    @(negedge clk);
    cache_valid = 1'b0; cpu_rden = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    start(1'b1, 1'b0, 32'h0000_7004, 2'b10, 1'b0, 32'h0);
    @(negedge clk);
    total++; if (cache_read !== 1'b1) $display("FAIL rm_req: got %b exp 1", cache_read); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total++; if ({cache_read, cpu_stall} !== 2'b00 || cache_addr !== 32'h0) $display("FAIL rm_drop: got read/stall %b addr %h exp 00 0", {cache_read, cpu_stall}, cache_addr); else pass_cnt++;
    rst = 1'b0; cpu_rden = 1'b0;
    @(negedge clk);
    total++; if ({cache_read, cpu_stall} !== 2'b00 || cpu_rdata !== 32'h0) $display("FAIL rm_idle: got read/stall %b rdata %h exp 00 0", {cache_read, cpu_stall}, cpu_rdata); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_word_load;
    test_byte_load;
    test_half_store;
    test_store_masks;
    test_wait_states;
    test_misaligned;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/l1_cpu_port.md
# l1_cpu_port

Word/byte access port between the OTTER multicycle core's memory interface and the L1 data cache's 256-bit line interface. It accepts one CPU load or store at a time and registers it. It then drives a line-addressed request to the cache and holds the core stalled until the cache responds. It returns a sign- or zero-extended load result, or produces a byte-masked store line. It sits directly upstream of the cache, which owns tags, replacement, and the memory-side burst.

## Interface
- `OFFSET_W`, default 5: byte-offset bits within a line (32-byte line).
- `LINE_W`, default 256: cache line width in bits, equal to 8·2^`OFFSET_W`.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `cpu_rden` in 1: load request. Held by the core until `cpu_stall` falls.
- `cpu_wren` in 1: store request. Held by the core until `cpu_stall` falls.
- `cpu_addr` in 32: byte address.
- `cpu_size` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `cpu_sign` in 1: extension mode. 1 = zero-extend load, 0 = sign-extend.
- `cpu_wdata` in 32: store data, right-aligned.
- `cpu_rdata` out 32: load result. Valid only in the DONE cycle.
- `cpu_stall` out 1: core must hold its request while high.
- `cpu_err` out 1: misaligned or illegal access. Valid only in the DONE cycle.
- `cache_read` out 1: line read request.
- `cache_write` out 1: masked line write request.
- `cache_addr` out 32: address with bits [4:0] forced to 0.
- `cache_wdata` out `LINE_W`: store data replicated into every lane.
- `cache_wmask` out 32: per-byte write enable for the line.
- `cache_rdata` in `LINE_W`: line data. Valid when `cache_valid` = 1.
- `cache_valid` in 1: cache completion pulse.

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE**
  - A request (`cpu_rden|cpu_wren`) is accepted immediately.
  - On accept, latch `cpu_addr`, `cpu_size`, `cpu_sign` and `cpu_wdata`, plus op = write if `cpu_wren`, else read.
  - `cpu_wren` wins if both requests are high; `cpu_rden` is then ignored.
  - Misaligned access means half with addr[0]=1, word with addr[1:0]≠0, or size=11. It goes straight to DONE with the error flag set and issues no cache request.
  - Otherwise go to REQ.
- **REQ**
  - Exactly one of `cache_read`/`cache_write` is high, driven from the latched registers.
  - It is held constant until `cache_valid` = 1.
  - On `cache_valid`, latch the load result and go to DONE.
- **DONE**
  - `cpu_stall` = 0 and `cpu_rdata`/`cpu_err` are valid.
  - Unconditionally go to IDLE.
  - A request still present in the following IDLE cycle is treated as a new access.
- **Load extraction**
  - word = `cache_rdata[addr[4:2]*32 +: 32]`.
  - Byte lane addr[1:0], half lane addr[1].
  - Extend to 32 bits per `cpu_sign`.
  - A word load ignores `cpu_sign`.
- **Store mask**
  - Byte: 1 bit at position addr[4:0].
  - Half: 2 bits starting at addr[4:0].
  - Word: 4 bits starting at addr[4:0].
  - All other `cache_wmask` bits are 0.
  - `cache_wdata`: the byte is replicated ×32, the half ×16, the word ×8.
- `cache_valid` is ignored outside REQ.
- **Reset**, including mid-REQ:
  - State → IDLE and latched registers are cleared.
  - The cache must tolerate an abandoned request, since `cache_read`/`cache_write` drop on the next edge.

## Timing
- **Reset values:**
  - `cpu_rdata` = 0, `cpu_err` = 0, `cpu_stall` = 0.
  - `cache_read` = 0, `cache_write` = 0.
  - `cache_addr` = 0, `cache_wdata` = 0, `cache_wmask` = 0.
- **`cpu_stall`** is combinational:
  - high in IDLE when a request is present;
  - high throughout REQ;
  - low in DONE.
- **Cache outputs** are registered-state driven. They are high only in REQ and 0 in IDLE and DONE.
- **Latency**, counting the accept cycle as 0:
  - the cache request is asserted in cycle 1;
  - with `cache_valid` in cycle k (k ≥ 1), DONE is cycle k+1;
  - minimum total is 3 cycles with the core stalled for 2;
  - an error access takes 2 cycles.
- Back-to-back accesses are separated by exactly one IDLE cycle after DONE.
- `cpu_rdata` and `cpu_err` hold their values until the next DONE. They are qualified only in DONE.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `cpu_rden`=1 → all outputs 0 and no `cache_read` during reset.
- **Word load:** word load at 0x0000_1008 with `cache_valid` in cycle 1 and line word 2 = 0xDEADBEEF → `cache_addr`=0x0000_1000, DONE in cycle 2, `cpu_rdata`=0xDEADBEEF, `cpu_err`=0.
- **Byte load extension:** byte load at 0x0000_2003 with line byte 3 = 0x80 → `cpu_rdata`=0xFFFFFF80 when `cpu_sign`=0, and 0x00000080 when `cpu_sign`=1.
- **Half store:** half store of 0x1234 at 0x0000_3006 → `cache_write`=1, `cache_wmask`=0x000000C0, `cache_wdata`=0x1234 replicated 16×, `cache_read`=0.
- **Wait states:** `cache_valid` delayed 6 cycles → `cache_read`/`cache_addr` stable for all REQ cycles and `cpu_stall` high until DONE. A `cache_valid` pulse injected during IDLE is ignored.
- **Misaligned / reset mid-access:**
  - Word load at 0x0000_4002 → no cache request, DONE in cycle 1 with `cpu_err`=1 and `cpu_rdata`=0.
  - Reset asserted during REQ → state IDLE and `cache_read`=0 on the next edge.
